// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART RX frame controller, its receiver and the host.
// slave is the controller's view; master is the host/receiver view.
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              enable;
  logic [15:0]       cfg_baud_div;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic              cfg_load;
  logic [15:0]       rx_baud_div;
  logic [1:0]        rx_parity;
  logic              rx_stop2;
  logic              rx_cfg_rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_framing_err;
  logic              rx_parity_err;
  logic              frame_done;
  logic [ADDR_W:0]   frame_len;
  logic [3:0]        frame_err;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [1:0]        state_o;

  modport slave (
    input  enable, cfg_baud_div, cfg_parity, cfg_stop2, cfg_load,
    input  rx_data, rx_valid, rx_framing_err, rx_parity_err,
    input  frame_ack, rd_addr,
    output rx_baud_div, rx_parity, rx_stop2, rx_cfg_rst,
    output frame_done, frame_len, frame_err, rd_data, state_o
  );

  modport master (
    output enable, cfg_baud_div, cfg_parity, cfg_stop2, cfg_load,
    output rx_data, rx_valid, rx_framing_err, rx_parity_err,
    output frame_ack, rd_addr,
    input  rx_baud_div, rx_parity, rx_stop2, rx_cfg_rst,
    input  frame_done, frame_len, frame_err, rd_data, state_o
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller for a 16x-oversampling UART receiver: owns the receiver config,
// delimits frames by inter-character silence and buffers one frame for the host.
module uart_rx_frame_ctrl #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned GAP_T15      = 17,
  parameter int unsigned GAP_T35      = 39,
  parameter logic [15:0] BAUD_DIV_RST = 16'd26
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_frame_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RECV, S_WAIT, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [15:0]        div_q, div_d;
  logic [3:0]         sub_q, sub_d;
  logic [7:0]         gap_q, gap_d;
  logic               pend_q, pend_d;
  logic [15:0]        pend_div_q, pend_div_d;
  logic [1:0]         pend_par_q, pend_par_d;
  logic               pend_stop2_q, pend_stop2_d;
  logic [15:0]        baud_q, baud_d;
  logic [1:0]         par_q, par_d;
  logic               stop2_q, stop2_d;
  logic               cfg_rst_q, cfg_rst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [3:0]         err_q, err_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   flen_q, flen_d;
  logic [3:0]         ferr_q, ferr_d;
  logic [1:0]         dbg_q, dbg_d;
  logic [7:0]         rd_data_q, rd_data_d;

  logic               tick16, bit_tick, gap_clr, apply, byte_err, mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [7:0]         mem_q [DEPTH];

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    sub_d        = sub_q;
    gap_d        = gap_q;
    pend_d       = pend_q;
    pend_div_d   = pend_div_q;
    pend_par_d   = pend_par_q;
    pend_stop2_d = pend_stop2_q;
    baud_d       = baud_q;
    par_d        = par_q;
    stop2_d      = stop2_q;
    cfg_rst_d    = 1'b0;
    len_d        = len_q;
    err_d        = err_q;
    done_d       = done_q;
    flen_d       = flen_q;
    ferr_d       = ferr_q;
    dbg_d        = dbg_q;
    rd_data_d    = mem_q[bus.rd_addr];
    tick16       = 1'b0;
    bit_tick     = 1'b0;
    gap_clr      = 1'b0;
    apply        = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = len_q[ADDR_W-1:0];
    byte_err     = bus.rx_framing_err | bus.rx_parity_err;

    // 16x tick divider and bit-time counter, free running
    if (div_q == 16'd0) begin
      div_d  = baud_q;
      tick16 = 1'b1;
    end else begin
      div_d = div_q - 16'd1;
    end
    if (tick16) begin
      sub_d    = sub_q + 4'd1;
      bit_tick = (sub_q == 4'hF);
    end

    case (state_q)
      S_INIT: begin
        if (gap_q >= 8'(GAP_T35)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.rx_valid) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          len_d     = LEN_W'(1);
          err_d     = {3'b000, byte_err};
          state_d   = S_RECV;
        end
      end
      S_RECV: begin
        if (gap_q >= 8'(GAP_T15)) begin
          state_d = S_WAIT;
          if (bus.rx_valid) err_d[2] = 1'b1;
        end else if (bus.rx_valid) begin
          err_d[0] = err_q[0] | byte_err;
          if (len_q == LEN_W'(DEPTH)) begin
            err_d[1] = 1'b1;
          end else begin
            mem_we = 1'b1;
            len_d  = len_q + LEN_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (bus.rx_valid) begin
          err_d[2] = 1'b1;
        end else if (gap_q >= 8'(GAP_T35)) begin
          done_d  = 1'b1;
          flen_d  = len_q;
          ferr_d  = err_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.rx_valid) ferr_d[3] = 1'b1;
        if (bus.frame_ack) begin
          done_d  = 1'b0;
          gap_clr = 1'b1;
          state_d = ferr_d[3] ? S_INIT : S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (!bus.enable) begin
      state_d = S_INIT;
      done_d  = 1'b0;
      gap_clr = 1'b1;
      mem_we  = 1'b0;
    end

    // Pending config lands only when (re)entering INIT or IDLE, then restarts the line sync
    if (pend_q && (state_d == S_INIT || state_d == S_IDLE) && (state_d != state_q)) begin
      apply   = 1'b1;
      state_d = S_INIT;
      gap_clr = 1'b1;
    end

    if (bus.cfg_load) begin
      pend_d       = 1'b1;
      pend_div_d   = bus.cfg_baud_div;
      pend_par_d   = bus.cfg_parity;
      pend_stop2_d = bus.cfg_stop2;
    end else if (apply) begin
      pend_d = 1'b0;
    end
    if (apply) begin
      baud_d  = pend_div_q;
      par_d   = pend_par_q;
      stop2_d = pend_stop2_q;
    end
    cfg_rst_d = apply;

    // A received byte restarts the silence measurement even on a bit_tick
    if (bus.rx_valid || gap_clr) begin
      gap_d = 8'd0;
    end else if (bit_tick && gap_q != 8'hFF) begin
      gap_d = gap_q + 8'd1;
    end

    // WAIT and HOLD share the 2-bit debug code; frame_done tells them apart
    case (state_d)
      S_INIT:  dbg_d = 2'd0;
      S_IDLE:  dbg_d = 2'd1;
      S_RECV:  dbg_d = 2'd2;
      default: dbg_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      div_q        <= 16'd0;
      sub_q        <= 4'd0;
      gap_q        <= 8'd0;
      pend_q       <= 1'b0;
      pend_div_q   <= 16'd0;
      pend_par_q   <= 2'd0;
      pend_stop2_q <= 1'b0;
      baud_q       <= BAUD_DIV_RST;
      par_q        <= 2'd0;
      stop2_q      <= 1'b0;
      cfg_rst_q    <= 1'b0;
      len_q        <= '0;
      err_q        <= 4'd0;
      done_q       <= 1'b0;
      flen_q       <= '0;
      ferr_q       <= 4'd0;
      dbg_q        <= 2'd0;
      rd_data_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sub_q        <= sub_d;
      gap_q        <= gap_d;
      pend_q       <= pend_d;
      pend_div_q   <= pend_div_d;
      pend_par_q   <= pend_par_d;
      pend_stop2_q <= pend_stop2_d;
      baud_q       <= baud_d;
      par_q        <= par_d;
      stop2_q      <= stop2_d;
      cfg_rst_q    <= cfg_rst_d;
      len_q        <= len_d;
      err_q        <= err_d;
      done_q       <= done_d;
      flen_q       <= flen_d;
      ferr_q       <= ferr_d;
      dbg_q        <= dbg_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Frame buffer; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= bus.rx_data;
  end

  assign bus.rx_baud_div = baud_q;
  assign bus.rx_parity   = par_q;
  assign bus.rx_stop2    = stop2_q;
  assign bus.rx_cfg_rst  = cfg_rst_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_len   = flen_q;
  assign bus.frame_err   = ferr_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.state_o     = dbg_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: a full-size instance for framing/config
// and a 4-byte instance for buffer overflow.
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if #(.ADDR_W(8)) ia ();
  uart_rx_frame_ctrl_if #(.ADDR_W(2)) ib ();

  uart_rx_frame_ctrl #(.ADDR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  uart_rx_frame_ctrl #(.ADDR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic pe);
    ia.rx_data = d; ia.rx_parity_err = pe; ia.rx_valid = 1'b1;
    idle(1);
    ia.rx_valid = 1'b0; ia.rx_parity_err = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    ib.rx_data = d; ib.rx_valid = 1'b1;
    idle(1);
    ib.rx_valid = 1'b0;
  endtask

  task automatic ack_a();
    ia.frame_ack = 1'b1;
    idle(1);
    ia.frame_ack = 1'b0;
  endtask

  task automatic wait_done_a(input int max, output int n);
    n = 0;
    while (!ia.frame_done && n < max) begin idle(1); n++; end
  endtask

  task automatic wait_state_a(input logic [1:0] s, input int max, output int n);
    n = 0;
    while (ia.state_o != s && n < max) begin idle(1); n++; end
  endtask

  task automatic read_a(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    ia.rd_addr = addr;
    idle(1);
    check(tag, 32'(ia.rd_data), 32'(exp));
  endtask

  int n;
  int pulses;

  initial begin
    ia.enable = 1'b0; ia.cfg_baud_div = 16'd0; ia.cfg_parity = 2'd0; ia.cfg_stop2 = 1'b0;
    ia.cfg_load = 1'b0; ia.rx_data = 8'd0; ia.rx_valid = 1'b0; ia.rx_framing_err = 1'b0;
    ia.rx_parity_err = 1'b0; ia.frame_ack = 1'b0; ia.rd_addr = 8'd0;
    ib.enable = 1'b0; ib.cfg_baud_div = 16'd0; ib.cfg_parity = 2'd0; ib.cfg_stop2 = 1'b0;
    ib.cfg_load = 1'b0; ib.rx_data = 8'd0; ib.rx_valid = 1'b0; ib.rx_framing_err = 1'b0;
    ib.rx_parity_err = 1'b0; ib.frame_ack = 1'b0; ib.rd_addr = 2'd0;
    idle(3);

    check("rst_baud", 32'(ia.rx_baud_div), 26);
    check("rst_parity", 32'(ia.rx_parity), 0);
    check("rst_stop2", 32'(ia.rx_stop2), 0);
    check("rst_cfg_rst", 32'(ia.rx_cfg_rst), 0);
    check("rst_done", 32'(ia.frame_done), 0);
    check("rst_len", 32'(ia.frame_len), 0);
    check("rst_err", 32'(ia.frame_err), 0);
    check("rst_rd_data", 32'(ia.rd_data), 0);
    check("rst_state", 32'(ia.state_o), 0);

    // Bring-up: divider 0 (bit = 16 clk), applied when INIT first hands over to IDLE
    rst = 1'b0; ia.enable = 1'b1; ib.enable = 1'b1;
    ia.cfg_load = 1'b1; ib.cfg_load = 1'b1;
    idle(1);
    ia.cfg_load = 1'b0; ib.cfg_load = 1'b0;
    idle(2);
    check("cfg0_pending_baud", 32'(ia.rx_baud_div), 26);
    n = 0;
    while (!ia.rx_cfg_rst && n < 18000) begin idle(1); n++; end
    check("cfg0_apply_seen", 32'(ia.rx_cfg_rst), 1);
    check("cfg0_baud_a", 32'(ia.rx_baud_div), 0);
    check("cfg0_baud_b", 32'(ib.rx_baud_div), 0);
    check("cfg0_state_init", 32'(ia.state_o), 0);
    idle(1);
    check("cfg0_rst_1cyc", 32'(ia.rx_cfg_rst), 0);
    wait_state_a(2'd1, 800, n);
    check("cfg0_idle_a", 32'(ia.state_o), 1);
    check("cfg0_idle_b", 32'(ib.state_o), 1);

    ack_a();
    check("ack_outside_hold", 32'(ia.state_o), 1);

    // Frame 1: three clean bytes at 11-bit spacing
    send_a(8'h01, 1'b0); idle(175);
    send_a(8'h03, 1'b0); idle(175);
    send_a(8'h10, 1'b0);
    wait_done_a(800, n);
    check("f1_done", 32'(ia.frame_done), 1);
    check("f1_latency_win", 32'(n >= 600 && n <= 630), 1);
    check("f1_len", 32'(ia.frame_len), 3);
    check("f1_err", 32'(ia.frame_err), 0);
    check("f1_state_hold", 32'(ia.state_o), 3);
    read_a(8'd0, 8'h01, "f1_mem0");
    read_a(8'd1, 8'h03, "f1_mem1");
    read_a(8'd2, 8'h10, "f1_mem2");
    ack_a();
    check("f1_ack_done", 32'(ia.frame_done), 0);
    check("f1_ack_idle", 32'(ia.state_o), 1);

    // Frame 2: parity error on the middle byte
    send_a(8'hAA, 1'b0); idle(175);
    send_a(8'h55, 1'b1); idle(175);
    send_a(8'h33, 1'b0);
    wait_done_a(800, n);
    check("f2_done", 32'(ia.frame_done), 1);
    check("f2_len", 32'(ia.frame_len), 3);
    check("f2_err", 32'(ia.frame_err), 32'h1);
    read_a(8'd1, 8'h55, "f2_mem1");
    ack_a();

    // Frame 3: second byte 20 bit times late
    send_a(8'h11, 1'b0); idle(319);
    send_a(8'h22, 1'b0);
    wait_done_a(900, n);
    check("f3_done", 32'(ia.frame_done), 1);
    check("f3_len", 32'(ia.frame_len), 1);
    check("f3_err", 32'(ia.frame_err), 32'h4);
    ack_a();

    // Overflow on the 4-byte instance
    for (int i = 0; i < 6; i++) begin
      send_b(8'(8'hA0 + i));
      idle(175);
    end
    n = 0;
    while (!ib.frame_done && n < 800) begin idle(1); n++; end
    check("ovf_done", 32'(ib.frame_done), 1);
    check("ovf_len", 32'(ib.frame_len), 4);
    check("ovf_err", 32'(ib.frame_err), 32'h2);
    for (int i = 0; i < 4; i++) begin
      ib.rd_addr = 2'(i);
      idle(1);
      check("ovf_mem", 32'(ib.rd_data), 32'(8'hA0 + i));
    end
    ib.frame_ack = 1'b1; idle(1); ib.frame_ack = 1'b0;
    check("ovf_ack_done", 32'(ib.frame_done), 0);

    // Overrun: byte arrives while the frame is held
    send_a(8'h42, 1'b0);
    wait_done_a(800, n);
    check("ovr_done", 32'(ia.frame_done), 1);
    send_a(8'h99, 1'b0);
    check("ovr_err", 32'(ia.frame_err), 32'h8);
    check("ovr_len", 32'(ia.frame_len), 1);
    ack_a();
    check("ovr_ack_done", 32'(ia.frame_done), 0);
    check("ovr_state_init", 32'(ia.state_o), 0);
    send_a(8'h66, 1'b0);
    idle(2);
    check("ovr_init_ignores", 32'(ia.state_o), 0);
    wait_state_a(2'd1, 700, n);
    check("ovr_resync_idle", 32'(ia.state_o), 1);
    check("ovr_resync_win", 32'(n >= 600), 1);

    // Disable mid-frame
    send_a(8'h12, 1'b0);
    check("en_recv", 32'(ia.state_o), 2);
    ia.enable = 1'b0;
    idle(1);
    check("en_off_init", 32'(ia.state_o), 0);
    check("en_off_done", 32'(ia.frame_done), 0);
    ia.enable = 1'b1;
    wait_state_a(2'd1, 700, n);
    check("en_resync_idle", 32'(ia.state_o), 1);

    // Config change requested mid-frame lands only after frame_ack
    send_a(8'h5A, 1'b0);
    ia.cfg_baud_div = 16'd5; ia.cfg_parity = 2'd1; ia.cfg_load = 1'b1;
    idle(1);
    ia.cfg_load = 1'b0;
    check("cfg1_hold_baud", 32'(ia.rx_baud_div), 0);
    check("cfg1_hold_par", 32'(ia.rx_parity), 0);
    idle(170);
    send_a(8'h5B, 1'b0);
    wait_done_a(800, n);
    check("cfg1_done", 32'(ia.frame_done), 1);
    check("cfg1_len", 32'(ia.frame_len), 2);
    check("cfg1_pre_ack_baud", 32'(ia.rx_baud_div), 0);
    check("cfg1_pre_ack_rst", 32'(ia.rx_cfg_rst), 0);
    ack_a();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (ia.rx_cfg_rst) pulses++;
      idle(1);
    end
    check("cfg1_rst_pulses", 32'(pulses), 1);
    check("cfg1_baud", 32'(ia.rx_baud_div), 5);
    check("cfg1_par", 32'(ia.rx_parity), 1);
    check("cfg1_state_init", 32'(ia.state_o), 0);

    // Async reset in the middle of a frame
    wait_state_a(2'd1, 4500, n);
    check("rstmid_idle", 32'(ia.state_o), 1);
    send_a(8'h77, 1'b0);
    check("rstmid_recv", 32'(ia.state_o), 2);
    rst = 1'b1;
    #1;
    check("rstmid_baud", 32'(ia.rx_baud_div), 26);
    check("rstmid_par", 32'(ia.rx_parity), 0);
    check("rstmid_state", 32'(ia.state_o), 0);
    check("rstmid_len", 32'(ia.frame_len), 0);
    check("rstmid_done", 32'(ia.frame_done), 0);
    idle(2);
    rst = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame-level controller for the 16x-oversampling UART receiver, used on the PLC fieldbus port in Modbus-RTU style.
- Owns the receiver's configuration: divider, parity and stop bits.
- Consumes its byte stream and delimits frames by inter-character silence (t1.5 / t3.5 in bit times).
- Buffers one frame in a RAM and hands it to the host with a done/ack handshake plus error status.

Parameters:
ADDR_W, 8, frame buffer address width; depth = 2**ADDR_W bytes
GAP_T15, 17, intra-frame silence limit in bit times (1.5 chars x 11 bits, rounded up)
GAP_T35, 39, end-of-frame silence in bit times (3.5 chars x 11 bits, rounded up)
BAUD_DIV_RST, 16'd26, reset value of rx_baud_div

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  controller enable; 0 forces S_INIT and clears the gap counter
cfg_baud_div  in  16  requested divider (16x tick period = value+1 clk)
cfg_parity  in  2  requested parity: 0 none, 1 even, 2 odd
cfg_stop2  in  1  requested 2 stop bits
cfg_load  in  1  pulse: capture cfg_* into the pending register
rx_baud_div  out  16  divider driven to the receiver
rx_parity  out  2  parity driven to the receiver
rx_stop2  out  1  stop setting driven to the receiver
rx_cfg_rst  out  1  1-cycle receiver reset, pulsed when new config is applied
rx_data  in  8  received byte
rx_valid  in  1  1-cycle byte strobe
rx_framing_err  in  1  framing error for the current byte (qualified by rx_valid)
rx_parity_err  in  1  parity error for the current byte (qualified by rx_valid)
frame_done  out  1  level; frame available, held until frame_ack
frame_len  out  ADDR_W+1  number of bytes stored
frame_err  out  4  [0] byte error, [1] overflow, [2] early byte, [3] overrun
frame_ack  in  1  pulse; host has consumed the frame
rd_addr  in  ADDR_W  buffer read address
rd_data  out  8  buffer read data, 1-cycle registered latency
state_o  out  2  current state, for debug

Behaviour:
Reset values:
- rx_baud_div = BAUD_DIV_RST; rx_parity = 0; rx_stop2 = 0; rx_cfg_rst = 0.
- frame_done = 0; frame_len = 0; frame_err = 0; rd_data = 0; state = S_INIT; pending flag = 0.

Bit timer:
- Free-running 16-bit divider reloads rx_baud_div on reaching 0 and emits a 16x tick.
- 4-bit counter over 16x ticks emits bit_tick once per 16 ticks.
- Gap counter (8 bit) increments on bit_tick, saturates at 255, and clears to 0 on rx_valid.

Config:
- cfg_load sets the pending flag and latches the cfg_* values; a later cfg_load overwrites them.
- Pending config is applied only on the cycle of entry to S_INIT or S_IDLE.
- On apply: outputs are updated, rx_cfg_rst pulses for 1 cycle, the gap counter clears, the state goes to S_INIT, and the pending flag clears.

States:
- S_INIT: wait for gap >= GAP_T35 -> S_IDLE. rx_valid here is ignored and restarts the gap.
- S_IDLE: on rx_valid, store the byte at address 0, set len = 1, clear err and OR in the byte errors -> S_RECV.
- S_RECV:
  - rx_valid with gap < GAP_T15: store at address len; len++; OR byte errors into err[0].
  - If len == 2**ADDR_W, do not store, do not increment, and set err[1].
  - gap >= GAP_T15 -> S_WAIT.
- S_WAIT:
  - rx_valid: set err[2], byte not stored, stay in S_WAIT; the gap restarts.
  - gap >= GAP_T35: frame_done = 1, latch frame_len and frame_err -> S_HOLD.
- S_HOLD:
  - rx_valid sets frame_err[3] while frame_done is high; the byte is dropped.
  - frame_ack: frame_done = 0, clear gap -> S_INIT if err[3] is set, else S_IDLE. Pending config is applied here.

Boundary and simultaneous events:
- rx_valid and bit_tick in the same cycle: the clear wins.
- frame_ack outside S_HOLD is ignored.
- A frame with errors is still delivered; the host discards it.
- enable = 0 mid-frame: discard the frame (frame_done = 0) -> S_INIT.
- Async rst mid-frame: all state returns to reset values; buffer contents are undefined.

Buffer read:
- Single-port-write / read RAM.
- rd_data = mem[rd_addr] registered every cycle, independent of state.

Test Plan:
- rst, baud_div = 0 (bit = 16 clk), idle 640 clk, then 3 bytes 0x01 0x03 0x10 at 11-bit spacing (176 clk), then silence -> frame_done rises 39 bit times (624 clk) after the last rx_valid; frame_len = 3, frame_err = 0; reading rd_addr 0..2 gives 01, 03, 10 one cycle later.
- Byte with rx_parity_err = 1 mid-frame -> frame delivered, frame_err = 4'b0001.
- Byte 20 bit times after the previous one -> first frame ends at 39 bits with frame_err[2] = 1; the late byte is not counted (frame_len unchanged).
- ADDR_W = 2, send 6 bytes back-to-back -> frame_len = 4, frame_err[1] = 1, mem[0..3] = the first 4 bytes.
- Byte while frame_done = 1 -> frame_err[3] = 1; after frame_ack, state = S_INIT, and a new frame is accepted only after 39 bits of silence.
- cfg_load (baud_div = 5, parity = 1) during S_RECV -> rx_* unchanged until frame_ack; then rx_baud_div = 5, rx_parity = 1, and a single rx_cfg_rst pulse. Assert rst mid-frame -> all outputs return to reset values immediately.
